// File: rtl/regfile_pkg.sv
// Shared constants and sizing helpers for the parametrised register file and its LED viewer.
package regfile_pkg;

    localparam logic LED_MODE_MANUAL = 1'b0;
    localparam logic LED_MODE_AUTO   = 1'b1;
    localparam logic LED_SRC_A       = 1'b0;
    localparam logic LED_SRC_B       = 1'b1;

    function automatic int unsigned nbytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Byte-index width; at least one bit even for a single-byte word.
    function automatic int unsigned sel_width(input int unsigned data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/led_byte_scanner.sv
// Registered LED byte viewer: manual byte select or auto-scan through the bytes of a word.
module led_byte_scanner
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SCAN_DIV = 16,
    localparam int unsigned NBYTES  = nbytes(DATA_W),
    localparam int unsigned SEL_W   = sel_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] word,
    output logic [7:0]        led
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NBYTES - 1);

    logic [DIV_W-1:0] div_q;
    logic [SEL_W-1:0] idx_q;
    logic             mode_q;
    logic [7:0]       led_q;
    logic [SEL_W-1:0] pick;
    logic [7:0]       byte_sel;

    // Out-of-range manual selects fall through to 8'h00.
    always_comb begin
        pick     = (mode == LED_MODE_MANUAL) ? sel : idx_q;
        byte_sel = 8'h00;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (pick == SEL_W'(b)) byte_sel = word[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            idx_q  <= '0;
            mode_q <= LED_MODE_MANUAL;
            led_q  <= 8'h00;
        end else begin
            mode_q <= mode;
            led_q  <= byte_sel;
            // Manual mode and the entry edge into auto both restart the scan.
            if (mode != LED_MODE_AUTO || mode_q != LED_MODE_AUTO) begin
                div_q <= '0;
                idx_q <= '0;
            end else if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign led = led_q;

endmodule

// File: rtl/param_regfile_led.sv
// Parametrised 1W/2R register file with LED byte viewer.
// Define REGFILE_BYPASS_EN for write-first forwarding on both read ports.
module param_regfile_led
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned DEPTH   = 2 ** ADDR_W,
    localparam int unsigned SEL_W   = sel_width(DATA_W)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic              Write_Reg,
    output logic [DATA_W-1:0] R_Data_A,
    output logic [DATA_W-1:0] R_Data_B,
    input  logic              LED_Src,
    input  logic              LED_Mode,
    input  logic [SEL_W-1:0]  LED_Sel,
    output logic [7:0]        LED
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_zero;
    logic [DATA_W-1:0] src_word;

    assign wr_zero = (ZERO_REG != 0) && (W_Addr == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (Write_Reg && !wr_zero) begin
            regs_q[W_Addr] <= W_Data;
        end
    end

    always_comb begin
        R_Data_A = regs_q[R_Addr_A];
        R_Data_B = regs_q[R_Addr_B];
        if (ZERO_REG != 0 && R_Addr_A == '0) R_Data_A = '0;
        if (ZERO_REG != 0 && R_Addr_B == '0) R_Data_B = '0;
`ifdef REGFILE_BYPASS_EN
        if (Write_Reg && !wr_zero && R_Addr_A == W_Addr) R_Data_A = W_Data;
        if (Write_Reg && !wr_zero && R_Addr_B == W_Addr) R_Data_B = W_Data;
`endif
    end

    assign src_word = (LED_Src == LED_SRC_A) ? R_Data_A : R_Data_B;

    led_byte_scanner #(
        .DATA_W   (DATA_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk   (Clk),
        .rst_n (Reset),
        .mode  (LED_Mode),
        .sel   (LED_Sel),
        .word  (src_word),
        .led   (LED)
    );

endmodule

// File: tb/tb_param_regfile_led.sv
// Self-checking bench for param_regfile_led: directed steps plus randomized traffic vs a reference model.
module tb_param_regfile_led;
    import regfile_pkg::*;

    localparam int unsigned SD = 4;
    localparam int unsigned NB = 4;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ra, rb, wa;
    logic [31:0] wd;
    logic        we, src, mode;
    logic [1:0]  sel;
    logic [31:0] rda, rdb;
    logic [7:0]  led;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mregs [32];
    bit          m_prev_auto;
    int unsigned m_scan_t;

    param_regfile_led #(
        .ADDR_W   (5),
        .DATA_W   (32),
        .SCAN_DIV (SD),
        .ZERO_REG (1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .R_Addr_A  (ra),
        .R_Addr_B  (rb),
        .W_Addr    (wa),
        .W_Data    (wd),
        .Write_Reg (we),
        .R_Data_A  (rda),
        .R_Data_B  (rdb),
        .LED_Src   (src),
        .LED_Mode  (mode),
        .LED_Sel   (sel),
        .LED       (led)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && a == wa) return wd;
`endif
        return mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        m_prev_auto = 1'b0;
        m_scan_t    = 0;
    endtask

    // One clock edge: predict LED from pre-edge state, apply model write, compare after edge.
    task automatic tick();
        logic [31:0] w;
        int unsigned idx;
        logic [7:0]  exp_led;
        w = (src == LED_SRC_B) ? mread(rb) : mread(ra);
        if (mode == LED_MODE_AUTO) begin
            if (!m_prev_auto) begin
                idx      = 0;
                m_scan_t = 0;
            end else begin
                idx = (m_scan_t / SD) % NB;
                m_scan_t++;
            end
        end else begin
            idx = sel;
        end
        exp_led     = (idx < NB) ? w[idx*8 +: 8] : 8'h00;
        m_prev_auto = (mode == LED_MODE_AUTO);
        if (we && wa != 5'd0) mregs[wa] = wd;
        @(posedge Clk);
        #1;
        check("led", {24'h0, led}, {24'h0, exp_led});
    endtask

    task automatic check_reads();
        #1;
        check("rd_a", rda, mread(ra));
        check("rd_b", rdb, mread(rb));
    endtask

    // Mid-cycle reset held across one edge so any pending write must be discarded.
    task automatic do_reset();
        Reset = 1'b0;
        model_clear();
        #1;
        check("rst_led_async", {24'h0, led}, 32'h0);
        check("rst_rd_a_async", rda, 32'h0);
        check("rst_rd_b_async", rdb, 32'h0);
        @(posedge Clk);
        #1;
        check("rst_led_held", {24'h0, led}, 32'h0);
        check("rst_wr_lost", dut.R_Data_A | dut.R_Data_B, 32'h0);
        Reset = 1'b1;
        we    = 1'b0;
    endtask

    logic [7:0] man_tab [4];

    initial begin
        man_tab[0] = 8'h78; man_tab[1] = 8'h56; man_tab[2] = 8'h34; man_tab[3] = 8'h12;
        Reset = 1'b0;
        ra = '0; rb = '0; wa = '0; wd = '0; we = 1'b0;
        src = LED_SRC_A; mode = LED_MODE_MANUAL; sel = '0;
        model_clear();
        #3 Reset = 1'b1;

        // 1. Arbitrary state, then asynchronous reset
        mode = LED_MODE_AUTO;
        for (int i = 0; i < 10; i++) begin
            wa = 5'($urandom_range(1, 31)); wd = $urandom; we = 1'b1;
            ra = wa; rb = 5'($urandom_range(0, 31)); src = 1'($urandom);
            tick();
        end
        ra = wa; rb = 5'd3; we = 1'b1; wd = 32'hDEAD_BEEF;
        mode = LED_MODE_MANUAL;
        do_reset();
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a); rb = 5'(31 - a);
            #1;
            check("rst_reg_a", rda, 32'h0);
            check("rst_reg_b", rdb, 32'h0);
        end

        // 2. Basic write/read and zero register
        wa = 5'd1; wd = 32'h1234_5678; we = 1'b1;
        tick();
        we = 1'b0; ra = 5'd1; rb = 5'd1;
        #1;
        check("wr1_a", rda, 32'h1234_5678);
        check("wr1_b", rdb, 32'h1234_5678);
        wa = 5'd0; wd = 32'hFFFF_FFFF; we = 1'b1;
        tick();
        we = 1'b0; ra = 5'd0; rb = 5'd0;
        #1;
        check("zero_a", rda, 32'h0);
        check("zero_b", rdb, 32'h0);

        // 3. Read during write
        ra = 5'd2; wa = 5'd2; wd = 32'hA5A5_0001; we = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_same_cycle", rda, 32'hA5A5_0001);
`else
        check("rdw_same_cycle", rda, 32'h0);
`endif
        tick();
        we = 1'b0;
        #1;
        check("rdw_after_edge", rda, 32'hA5A5_0001);

        // 4. Manual byte select
        ra = 5'd1; src = LED_SRC_A; mode = LED_MODE_MANUAL;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            check("manual_const", {24'h0, led}, {24'h0, man_tab[s]});
        end
        src = LED_SRC_B; rb = 5'd0;
        tick();
        check("manual_src_b_zero", {24'h0, led}, 32'h0);

        // 5. Auto scan, then manual and back restarts at byte 0
        src = LED_SRC_A; mode = LED_MODE_AUTO;
        for (int i = 0; i < 20; i++) tick();
        mode = LED_MODE_MANUAL; sel = 2'd3;
        tick();
        mode = LED_MODE_AUTO;
        tick();
        check("auto_restart", {24'h0, led}, 32'h78);
        for (int i = 0; i < 6; i++) tick();

        // 6. Randomized traffic with a mid-scan, mid-write reset
        for (int i = 0; i < 160; i++) begin
            ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7)); wd = $urandom; we = 1'($urandom);
            src = 1'($urandom); sel = 2'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if (i == 80) begin
                mode = LED_MODE_AUTO; we = 1'b1; wa = 5'd5; ra = 5'd5; rb = 5'd5;
                do_reset();
                tick();
                check("post_rst_restart", {24'h0, led}, 32'h0);
            end else begin
                check_reads();
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
